// File: rtl/reduct_pkg.sv
// Shared definitions for the reduction tree: the gather FSM state encoding
// and the identity (pad) word for each supported reduction operator.
package reduct_pkg;

  localparam int unsigned REDUCT_MAX_DATA = 1024;

  typedef enum logic {
    FILL,
    HOLD
  } state_e;

  // Identity of the reduction: all ones for AND, all zeros for OR/XOR and anything else.
  function automatic logic [REDUCT_MAX_DATA-1:0] reduct_pad(input string ope, input int unsigned data);
    logic [REDUCT_MAX_DATA-1:0] pad;
    pad = '0;
    if (ope == "and") begin
      for (int unsigned i = 0; i < REDUCT_MAX_DATA; i++) begin
        if (i < data) pad[i] = 1'b1;
      end
    end
    return pad;
  endfunction

endpackage

// File: rtl/reduct_gather.sv
// Collects DATA-wide words into an IN-slot batch for the reduction tree,
// padding unfilled slots with the operator identity so short batches reduce correctly.
module reduct_gather
  import reduct_pkg::*;
#(
  parameter string       OPE  = "or",
  parameter int unsigned IN   = 4,
  parameter int unsigned DATA = 16
) (
  input  logic                            clk,
  input  logic                            reset_,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA-1:0]                 in_data,
  input  logic                            in_last,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IN-1:0][DATA-1:0]         out_vec,
  output logic [IN-1:0]                   out_mask,
  output logic [$clog2(IN+1)-1:0]         out_cnt
);

  localparam int unsigned    CW  = $clog2(IN + 1);
  localparam logic [DATA-1:0] PAD = DATA'(reduct_pad(OPE, DATA));

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IN-1:0]   mask_q, mask_d;
  logic [IN-1:0]   wr_sel;
  logic            clr;
  logic            accept;
  logic            close;

  assign in_ready = reset_ & ((state_q == FILL) | ((state_q == HOLD) & out_ready));
  assign accept   = in_valid & in_ready;
  // flush alongside an accepted word behaves exactly like in_last
  assign close    = in_last | flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    wr_sel  = '0;
    clr     = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          for (int unsigned k = 0; k < IN; k++) begin
            wr_sel[k] = (cnt_q == CW'(k));
          end
          mask_d = mask_q | wr_sel;
          cnt_d  = cnt_q + CW'(1);
          if (close || (cnt_q == CW'(IN - 1))) state_d = HOLD;
        end else if (flush && (cnt_q != '0)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          // Retire the batch; a word accepted in the same cycle seeds slot 0 of the next.
          clr     = 1'b1;
          state_d = FILL;
          cnt_d   = '0;
          mask_d  = '0;
          if (accept) begin
            wr_sel[0] = 1'b1;
            mask_d    = wr_sel;
            cnt_d     = CW'(1);
            if ((IN == 1) || close) state_d = HOLD;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= FILL;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  for (genvar k = 0; k < IN; k++) begin : g_slot
    logic [DATA-1:0] slot_q;

    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        slot_q <= PAD;
      end else if (wr_sel[k]) begin
        slot_q <= in_data;
      end else if (clr) begin
        slot_q <= PAD;
      end
    end

    assign out_vec[k] = slot_q;
  end

  assign out_valid = (state_q == HOLD);
  assign out_mask  = mask_q;
  assign out_cnt   = cnt_q;

endmodule
